pipeline_hazard_controller: RTL
===============================

# pipeline_hazard_controller

Hazard and forwarding controller for the five-stage MIPS pipeline. Tracks destination registers of instructions in EX, MEM and WB. Decides each cycle whether the instruction in ID may advance. Drives the PC and IF/ID load enables, the ID/EX bubble, the operand-forwarding selects, and a multi-cycle HI/LO (mult/div) busy interlock.

## Interface
- `MULDIV_CYCLES`, default 4: cycles the HI/LO unit stays busy after a mult/div issues; legal range 2–15.
- `Clk` in 1: pipeline clock; all state updates on rising edge.
- `Reset` in 1: synchronous, active-high; clears all tracking and the FSM.
- `ID_RS`, `ID_RT` in 5: source register numbers of the ID instruction.
- `ID_USES_RS`, `ID_USES_RT` in 1: the ID instruction reads that source.
- `ID_DEST` in 5: destination register of the ID instruction.
- `ID_RF_ENABLE` in 1: the ID instruction writes the register file.
- `ID_LOAD_INSTR` in 1: the ID instruction is a load.
- `ID_MULDIV_START` in 1: the ID instruction is mult/div.
- `ID_USES_HILO` in 1: the ID instruction is mfhi/mflo/mthi/mtlo.
- `PC_LE` out 1: PC load enable.
- `IF_ID_LE` out 1: IF/ID register load enable.
- `ID_EX_BUBBLE` out 1: forces ID/EX control inputs to zero this cycle.
- `FWD_A_SEL`, `FWD_B_SEL` out 2: operand A (rs) and operand B (rt) source. 00 = register file, 01 = EX result, 10 = MEM result, 11 = WB result.
- `MULDIV_BUSY` out 1: HI/LO unit occupied.
- `STALL_COUNT` out 16: saturating count of stall cycles.

## Operation
- **Tracking entries**:
  - EX, MEM and WB each hold {valid, dest[4:0], we, load}.
  - Every cycle the entries shift: WB←MEM, MEM←EX.
  - EX←ID fields when `STALL=0`; EX←invalid when `STALL=1`.
  - An entry counts as a hazard source only if valid, we=1 and dest≠0.
- **Load-use stall**: `LU = EX.load & hazard-source & ((ID_USES_RS & EX.dest==ID_RS) | (ID_USES_RT & EX.dest==ID_RT))`.
- **HI/LO stall**: `HL = MULDIV_BUSY & (ID_USES_HILO | ID_MULDIV_START)`.
- **Combined stall**: `STALL = LU | HL`. If both are true, one stall cycle results, not two.
- **Effect of `STALL=1`**: `PC_LE=0`, `IF_ID_LE=0`, `ID_EX_BUBBLE=1`. Otherwise these three are 1, 1, 0.
- **Forwarding, per operand**:
  - Priority EX > MEM > WB; the first matching hazard-source entry wins; with no match the select is 00.
  - A source register of 0 always selects 00.
  - Selects are produced even when `STALL=1`; the datapath ignores them while the bubble is in.
  - A load in EX never drives select 01, because `LU` stalls first. After the stall the load sits in MEM and the select becomes 10.
- **Mult/div FSM**, states IDLE and BUSY:
  - IDLE→BUSY: `ID_MULDIV_START & ~STALL`. The counter loads `MULDIV_CYCLES-1`.
  - BUSY: the counter decrements each cycle. At counter==0 the FSM returns to IDLE on the next edge.
  - `MULDIV_BUSY=1` exactly while in BUSY, i.e. for `MULDIV_CYCLES` cycles after the issue edge.
  - A mult/div arriving in ID while BUSY stalls until the FSM is IDLE, then issues.
- **`STALL_COUNT`**: +1 on every edge where `STALL=1`; saturates at 16'hFFFF.
- **Reset** (also when asserted mid-operation, including mid-mult/div):
  - All entries invalid, FSM IDLE, counter 0, `STALL_COUNT` 0.
  - Resulting outputs: `PC_LE=1`, `IF_ID_LE=1`, `ID_EX_BUBBLE=0`, both FWD selects 00, `MULDIV_BUSY=0`, `STALL_COUNT=0`.

## Timing
- `STALL`, the LE/bubble outputs and the FWD selects are combinational from the ID inputs plus registered state. They are valid in the same cycle and settle before the `Clk` edge.
- `MULDIV_BUSY` and `STALL_COUNT` are registered outputs.
- Load-use penalty is exactly 1 cycle. HI/LO penalty is the remaining busy cycles.
- Entry shift and FSM update occur on the same edge; a bubble inserted on edge N is visible in EX during cycle N+1.

## Structure
- **Package `pipeline_hazard_pkg`**:
  - FWD select constants: FWD_RF=2'b00, FWD_EX=2'b01, FWD_MEM=2'b10, FWD_WB=2'b11.
  - FSM state encoding: IDLE=1'b0, BUSY=1'b1.
  - Tracking-entry field widths.
- **Sub-module `muldiv_busy_timer`**:
  - Holds the FSM and down-counter.
  - Inputs: `Clk`, `Reset`, start.
  - Output: busy.
- The forwarding comparator stays inline, instantiated once per operand.

## Test plan
1. **Reset**: assert `Reset` for 2 cycles with arbitrary inputs → `PC_LE=1`, `IF_ID_LE=1`, `ID_EX_BUBBLE=0`, FWD 00/00, `MULDIV_BUSY=0`, `STALL_COUNT=0`.
2. **Load-use**: `lw $8` then `add $9,$8,$10` → one cycle of `PC_LE=0` with bubble=1. The next cycle has `FWD_A_SEL=10`, no stall, and `STALL_COUNT=1`.
3. **Forwarding priority**: `add $5`, `sub $5`, then `or $6,$5,$5` in consecutive issues → `FWD_A_SEL=FWD_B_SEL=01`. Repeat with dest $0 → selects 00.
4. **Mult busy**: `mult` issued with `MULDIV_CYCLES=4`, then `mflo` next in ID → `mflo` stalls 4 cycles and advances on the cycle `MULDIV_BUSY` falls. `STALL_COUNT=4`.
5. **Combined stall**: load-use hazard coincides with an HI/LO stall → a single stall per cycle and a single counter increment per cycle.
6. **Reset mid-operation**: `Reset` asserted during BUSY with counter=2 → next cycle `MULDIV_BUSY=0` and a pending `mflo` proceeds without stall.

Source files
------------

// File: rtl/pipeline_hazard_pkg.sv
// Shared types and constants for the MIPS hazard/forwarding controller.
package pipeline_hazard_pkg;
  localparam int REG_W = 5;
  localparam int MD_CNT_W = 4;

  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_EX  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;
  localparam logic [1:0] FWD_WB  = 2'b11;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} md_state_e;

  typedef struct packed {
    logic             valid;
    logic [REG_W-1:0] dest;
    logic             we;
    logic             load;
  } hz_entry_t;

  function automatic logic hz_src(input hz_entry_t e);
    return e.valid && e.we && (e.dest != '0);
  endfunction
endpackage

// File: rtl/pipeline_hazard_controller_muldiv.sv
// HI/LO unit busy timer: IDLE/BUSY FSM with a down-counter; busy is registered.
module muldiv_busy_timer
  import pipeline_hazard_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic Clk,
  input  logic Reset,
  input  logic start,
  output logic busy
);
  md_state_e           state_q;
  logic [MD_CNT_W-1:0] cnt_q;

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (start) begin
          state_q <= BUSY;
          cnt_q   <= MD_CNT_W'(MULDIV_CYCLES - 1);
          busy    <= 1'b1;
        end
        BUSY: if (cnt_q == '0) begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
        default: begin
          state_q <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: rtl/pipeline_hazard_controller.sv
// Load-use / HI-LO stall decision, EX>MEM>WB operand forwarding and stall counter.
module pipeline_hazard_controller
  import pipeline_hazard_pkg::*;
#(
  parameter int MULDIV_CYCLES = 4
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] ID_RS,
  input  logic [REG_W-1:0] ID_RT,
  input  logic             ID_USES_RS,
  input  logic             ID_USES_RT,
  input  logic [REG_W-1:0] ID_DEST,
  input  logic             ID_RF_ENABLE,
  input  logic             ID_LOAD_INSTR,
  input  logic             ID_MULDIV_START,
  input  logic             ID_USES_HILO,
  output logic             PC_LE,
  output logic             IF_ID_LE,
  output logic             ID_EX_BUBBLE,
  output logic [1:0]       FWD_A_SEL,
  output logic [1:0]       FWD_B_SEL,
  output logic             MULDIV_BUSY,
  output logic [15:0]      STALL_COUNT
);
  hz_entry_t   ex_q, mem_q, wb_q, ex_d;
  logic        lu, hl, stall;
  logic [15:0] stall_cnt_q;

  function automatic logic [1:0] fwd_sel(input logic [REG_W-1:0] src,
                                         input hz_entry_t ex, input hz_entry_t mem,
                                         input hz_entry_t wb);
    if (src == '0)                     return FWD_RF;
    if (hz_src(ex)  && ex.dest == src) return FWD_EX;
    if (hz_src(mem) && mem.dest == src) return FWD_MEM;
    if (hz_src(wb)  && wb.dest == src) return FWD_WB;
    return FWD_RF;
  endfunction

  always_comb begin
    lu = ex_q.load && hz_src(ex_q) &&
         ((ID_USES_RS && ex_q.dest == ID_RS) || (ID_USES_RT && ex_q.dest == ID_RT));
    hl = MULDIV_BUSY && (ID_USES_HILO || ID_MULDIV_START);
    stall = lu || hl;
    PC_LE        = !stall;
    IF_ID_LE     = !stall;
    ID_EX_BUBBLE = stall;
    FWD_A_SEL    = fwd_sel(ID_RS, ex_q, mem_q, wb_q);
    FWD_B_SEL    = fwd_sel(ID_RT, ex_q, mem_q, wb_q);
    ex_d = stall ? '0 : '{valid: 1'b1, dest: ID_DEST, we: ID_RF_ENABLE, load: ID_LOAD_INSTR};
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      ex_q        <= '0;
      mem_q       <= '0;
      wb_q        <= '0;
      stall_cnt_q <= '0;
    end else begin
      ex_q  <= ex_d;
      mem_q <= ex_q;
      wb_q  <= mem_q;
      if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign STALL_COUNT = stall_cnt_q;

  // A mult/div only issues once it is allowed to leave ID.
  muldiv_busy_timer #(.MULDIV_CYCLES(MULDIV_CYCLES)) u_md (
    .Clk   (Clk),
    .Reset (Reset),
    .start (ID_MULDIV_START && !stall),
    .busy  (MULDIV_BUSY)
  );
endmodule
